// File: rtl/eq2_sweep_ctrl.sv
// Self-test sweep controller for a W-bit equality comparator: drives every
// {a,b} pair, waits SETTLE cycles, samples aeqb and records mismatches.
module eq2_sweep_ctrl #(
  parameter int W      = 2,
  parameter int SETTLE = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic [W-1:0]   a,
  output logic [W-1:0]   b,
  input  logic           aeqb,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [2*W:0]   err_cnt,
  output logic [2*W-1:0] first_err_vec,
  output logic           first_err_valid
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  localparam logic [7:0]   LP_SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [2*W-1:0] LP_VEC_ONE   = 1;
  localparam logic [2*W:0]   LP_ERR_ONE   = 1;

  logic [1:0]     r_state;
  logic [2*W-1:0] r_vec;
  logic [7:0]     r_cnt;
  logic [2*W:0]   r_err;
  logic [2*W-1:0] r_first;
  logic           r_first_valid;
  logic           r_pass;

  logic w_exp;
  logic w_mis;
  logic w_last;

  assign a = r_vec[2*W-1:W];
  assign b = r_vec[W-1:0];

  // Expected result comes from the registered operands, so it is stable in SAMPLE.
  assign w_exp  = (a == b);
  assign w_mis  = (aeqb != w_exp);
  assign w_last = &r_vec;

  assign busy            = (r_state == ST_DRIVE) || (r_state == ST_SAMPLE);
  assign done            = (r_state == ST_FINISH);
  assign pass            = r_pass;
  assign err_cnt         = r_err;
  assign first_err_vec   = r_first;
  assign first_err_valid = r_first_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_vec         <= '0;
      r_cnt         <= '0;
      r_err         <= '0;
      r_first       <= '0;
      r_first_valid <= 1'b0;
      r_pass        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state       <= ST_DRIVE;
            r_vec         <= '0;
            r_cnt         <= '0;
            r_err         <= '0;
            r_first_valid <= 1'b0;
            r_pass        <= 1'b0;
          end
        end
        ST_DRIVE: begin
          r_cnt <= r_cnt + 8'd1;
          if (r_cnt == LP_SETTLE_LAST) begin
            r_state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (w_mis) begin
            r_err <= r_err + LP_ERR_ONE;
            if (!r_first_valid) begin
              r_first       <= r_vec;
              r_first_valid <= 1'b1;
            end
          end
          if (w_last) begin
            r_state <= ST_FINISH;
          end else begin
            r_vec   <= r_vec + LP_VEC_ONE;
            r_cnt   <= '0;
            r_state <= ST_DRIVE;
          end
        end
        default: begin
          // r_err already includes the final sample taken in the previous cycle.
          r_pass  <= (r_err == '0);
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eq2_sweep_ctrl.sv
// Bench for eq2_sweep_ctrl: injectable comparator faults, table-driven and
// randomized sweeps against a per-vector reference model.
module tb_eq2_sweep_ctrl;

  localparam int W = 2;
  localparam int NV = 16;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic sel;
  int   mode;
  logic [15:0] mask;

  logic [W-1:0] a0, b0, a1, b1;
  logic aeqb0, aeqb1;
  logic busy0, done0, pass0, fev0, busy1, done1, pass1, fev1;
  logic [2*W:0] err0, err1;
  logic [2*W-1:0] fvec0, fvec1;
  logic start0, start1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Comparator stand-in: 0 correct, 1 stuck-0, 2 stuck-1, 3 LSB-only, 4 per-vector fault mask
  function automatic logic cmp(input int m, input logic [15:0] msk,
                               input logic [W-1:0] x, input logic [W-1:0] y);
    logic eq;
    eq = (x == y);
    case (m)
      1: return 1'b0;
      2: return 1'b1;
      3: return (x[0] == y[0]);
      4: return eq ^ msk[{x, y}];
      default: return eq;
    endcase
  endfunction

  assign aeqb0  = cmp(mode, mask, a0, b0);
  assign aeqb1  = cmp(mode, mask, a1, b1);
  assign start0 = start & ~sel;
  assign start1 = start & sel;

  eq2_sweep_ctrl #(.W(W), .SETTLE(4)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .a(a0), .b(b0), .aeqb(aeqb0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
    .first_err_vec(fvec0), .first_err_valid(fev0)
  );

  eq2_sweep_ctrl #(.W(W), .SETTLE(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .aeqb(aeqb1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .first_err_vec(fvec1), .first_err_valid(fev1)
  );

  logic [W-1:0] s_a, s_b;
  logic s_busy, s_done, s_pass, s_fev;
  logic [2*W:0] s_err;
  logic [2*W-1:0] s_fvec;
  assign s_a    = sel ? a1 : a0;
  assign s_b    = sel ? b1 : b0;
  assign s_busy = sel ? busy1 : busy0;
  assign s_done = sel ? done1 : done0;
  assign s_pass = sel ? pass1 : pass0;
  assign s_fev  = sel ? fev1 : fev0;
  assign s_err  = sel ? err1 : err0;
  assign s_fvec = sel ? fvec1 : fvec0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: walk every operand pair in order, compare faulty vs ideal result.
  task automatic model(input int m, input logic [15:0] msk,
                       output int e_cnt, output int e_first, output int e_fv);
    int av, bv;
    logic got;
    e_cnt = 0; e_first = 0; e_fv = 0;
    for (int v = 0; v < NV; v++) begin
      av  = v / 4;
      bv  = v % 4;
      got = cmp(m, msk, 2'(av), 2'(bv));
      if (got != (av == bv)) begin
        if (e_fv == 0) e_first = v;
        e_fv = 1;
        e_cnt++;
      end
    end
  endtask

  task automatic check_results(input string tag, input int e_cnt, input int e_first,
                               input int e_fv);
    check({tag, "_err_cnt"}, int'(s_err), e_cnt);
    check({tag, "_fev"}, int'(s_fev), e_fv);
    check({tag, "_pass"}, int'(s_pass), (e_cnt == 0) ? 1 : 0);
    if (e_fv != 0) check({tag, "_first_vec"}, int'(s_fvec), e_first);
  endtask

  // Cycle c counts negedges after the start edge; done is due at 16*(settle+1)+1.
  task automatic run_sweep(input string tag, input int settle, input int restart_at,
                           input int reset_at, input bit hold_start);
    int holdv[NV];
    int prev, order_bad, hold_bad, busy_cnt, done_c, extra_done, c;
    for (int v = 0; v < NV; v++) holdv[v] = 0;
    prev = 0; order_bad = 0; hold_bad = 0; busy_cnt = 0; done_c = -1; extra_done = 0;
    @(negedge clk) start = 1'b1;
    for (c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (c == 1 && !hold_start) start = 1'b0;
      if (c == reset_at) begin
        reset = 1'b1;
        #1;
        check({tag, "_async_reset"},
              int'({s_busy, s_done, s_pass, s_err, s_fvec, s_fev, s_a, s_b}), 0);
        @(negedge clk) reset = 1'b0;
        for (int k = 0; k < 100; k++) begin
          @(negedge clk);
          if (s_done || s_busy) extra_done++;
        end
        check({tag, "_no_done_after_reset"}, extra_done, 0);
        return;
      end
      if (restart_at != 0 && c == restart_at) start = 1'b1;
      if (restart_at != 0 && c == restart_at + 1) start = 1'b0;
      if (s_busy) begin
        busy_cnt++;
        if (int'({s_a, s_b}) < prev) order_bad++;
        prev = int'({s_a, s_b});
        holdv[prev]++;
      end
      if (s_done) begin
        done_c = c;
        break;
      end
    end
    check({tag, "_done_cycle"}, done_c, NV * (settle + 1) + 1);
    check({tag, "_busy_cycles"}, busy_cnt, NV * (settle + 1));
    check({tag, "_busy_at_done"}, int'(s_busy), 0);
    for (int v = 0; v < NV; v++) if (holdv[v] != settle + 1) hold_bad++;
    check({tag, "_hold_per_vector"}, hold_bad, 0);
    check({tag, "_scan_order"}, order_bad, 0);
    @(negedge clk);
    if (hold_start) begin
      check({tag, "_idle_gap"}, int'(s_busy), 0);
      @(negedge clk);
      check({tag, "_auto_restart"}, int'(s_busy), 1);
      start = 1'b0;
      done_c = -1;
      for (int k = 0; k < 400; k++) begin
        @(negedge clk);
        if (s_done) begin done_c = k; break; end
      end
      check({tag, "_restart_done_seen"}, int'(done_c >= 0), 1);
      @(negedge clk);
    end else begin
      check({tag, "_single_done"}, int'(s_done), 0);
    end
  endtask

  typedef struct {
    int mode;
    int e_err;
    int e_first;
    int e_fv;
  } rec_t;

  rec_t tbl[5];
  int m_cnt, m_first, m_fv;

  initial begin
    tbl[0] = '{mode: 0, e_err: 0,  e_first: 0, e_fv: 0};
    tbl[1] = '{mode: 1, e_err: 4,  e_first: 0, e_fv: 1};
    tbl[2] = '{mode: 2, e_err: 12, e_first: 1, e_fv: 1};
    tbl[3] = '{mode: 3, e_err: 4,  e_first: 2, e_fv: 1};
    tbl[4] = '{mode: 0, e_err: 0,  e_first: 0, e_fv: 0};

    reset = 1'b1; start = 1'b0; sel = 1'b0; mode = 0; mask = '0;
    repeat (3) @(negedge clk);
    check("reset_dut0", int'({busy0, done0, pass0, err0, fvec0, fev0, a0, b0}), 0);
    check("reset_dut1", int'({busy1, done1, pass1, err1, fvec1, fev1, a1, b1}), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      mode = tbl[i].mode;
      run_sweep($sformatf("tbl%0d", i), 4, 0, 0, 1'b0);
      check_results($sformatf("tbl%0d", i), tbl[i].e_err, tbl[i].e_first, tbl[i].e_fv);
    end

    mode = 0;
    run_sweep("restart_ignored", 4, 30, 0, 1'b0);
    check_results("restart_ignored", 0, 0, 0);

    mode = 1;
    run_sweep("mid_reset", 4, 0, 40, 1'b0);
    mode = 0;
    run_sweep("after_reset", 4, 0, 0, 1'b0);
    check_results("after_reset", 0, 0, 0);

    run_sweep("held_start", 4, 0, 0, 1'b1);
    check_results("held_start", 0, 0, 0);

    mode = 4;
    for (int i = 0; i < 8; i++) begin
      mask = 16'($urandom);
      run_sweep($sformatf("rand%0d", i), 4, 0, 0, 1'b0);
      model(mode, mask, m_cnt, m_first, m_fv);
      check_results($sformatf("rand%0d", i), m_cnt, m_first, m_fv);
    end

    sel = 1'b1;
    mode = 0;
    run_sweep("settle1", 1, 0, 0, 1'b0);
    check_results("settle1", 0, 0, 0);
    mode = 4;
    mask = 16'($urandom) | 16'h0100;
    run_sweep("settle1_rand", 1, 0, 0, 1'b0);
    model(mode, mask, m_cnt, m_first, m_fv);
    check_results("settle1_rand", m_cnt, m_first, m_fv);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/eq2_sweep_ctrl.md
Name: eq2_sweep_ctrl

Overview:
Synthesizable self-test controller for the 2-bit equality comparator (eq2) and its W-bit generalisations. On a start pulse it drives every operand pair into an external comparator instance, holds each pair for a programmable settle time, samples the comparator's equality output and checks it against an internally computed expected value. It reports pass/fail, the error count and the first failing vector. It sits on the FPGA board between the switch/button I/O and the comparator under test.

Parameters:
W, 2, operand width; the sweep covers 2^(2W) vectors.
SETTLE, 4, cycles each vector is held before sampling; legal range is 1 to 255.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request a sweep; sampled only in IDLE
a  out  W  operand a to comparator
b  out  W  operand b to comparator
aeqb  in  1  comparator result, 1 = equal
busy  out  1  high while a sweep is in progress
done  out  1  one-cycle pulse when a sweep completes
pass  out  1  1 = last sweep had zero mismatches; held until the next start
err_cnt  out  2W+1  mismatch count of the last or current sweep
first_err_vec  out  2W  {a,b} of the first mismatch
first_err_valid  out  1  first_err_vec holds a captured mismatch

Behaviour:
- Reset values: all outputs 0; state IDLE; vector counter vec 0; settle counter 0.
- Operand mapping: a = vec[2W-1:W], b = vec[W-1:0]. Vectors are scanned in order 0 to 2^(2W)-1.
- Expected value: exp = (a == b), computed combinationally from the registered a and b.
- States:
  - IDLE:
    - busy=0.
    - start=1 moves to DRIVE. On the same edge: vec, settle counter, err_cnt, first_err_valid and pass all clear to 0.
  - DRIVE:
    - busy=1; a and b are stable.
    - The settle counter increments each cycle.
    - When the counter reaches SETTLE-1, move to SAMPLE.
  - SAMPLE (1 cycle):
    - If aeqb != exp: err_cnt increments.
    - If aeqb != exp and first_err_valid=0: first_err_vec <= vec and first_err_valid <= 1.
    - If vec is all ones: move to FINISH.
    - Otherwise: vec increments, the settle counter clears, and the state returns to DRIVE.
  - FINISH (1 cycle):
    - done=1 and busy=0.
    - pass <= (err_cnt == 0), using the final err_cnt including the last sample.
    - Move to IDLE.
- Latency: start accepted at edge k; busy is high from cycle k+1 for 2^(2W)*(SETTLE+1) cycles; done is high in the following cycle. For W=2, SETTLE=4 this is 80 busy cycles, with done in cycle k+81.
- aeqb is sampled only in SAMPLE; its value in DRIVE is ignored (allows for comparator settling and glitches).
- err_cnt cannot overflow, because its width 2W+1 holds 2^(2W). No saturation logic is needed.
- start while busy (DRIVE, SAMPLE or FINISH) is ignored. No queuing.
- start held high continuously: a new sweep begins on the first IDLE cycle after FINISH.
- pass, err_cnt and first_err_* remain valid in IDLE until the next accepted start. err_cnt is live during a sweep.
- Reset asserted mid-sweep: everything returns immediately (asynchronously) to reset values. No done pulse is generated. The next start runs a full sweep from vec 0.
- a and b change only on the edge leaving SAMPLE, i.e. they are glitch-free registered outputs.

Test Plan:
1. Correct comparator (aeqb = (a==b)), W=2, SETTLE=4, start pulse: busy for 80 cycles, then a single done pulse, pass=1, err_cnt=0, first_err_valid=0; a,b visit 00/00 through 11/11 in order.
2. aeqb stuck at 0: pass=0, err_cnt=4, first_err_vec=4'b0000, first_err_valid=1.
3. aeqb stuck at 1: pass=0, err_cnt=12, first_err_vec=4'b0001.
4. Faulty comparator aeqb = (a[0]==b[0]): err_cnt=4, first_err_vec=4'b0010 (a=00, b=10). Second sweep with a correct comparator clears the results: pass=1, err_cnt=0.
5. start pulsed again at busy cycle 30: ignored, with done still at cycle 81 and exactly one done pulse. Then reset asserted at busy cycle 40 of a new sweep: all outputs 0 immediately and no done. The next start completes normally with pass=1.
6. SETTLE=1: 32 busy cycles; each vector is held for exactly 2 cycles (1 DRIVE + 1 SAMPLE); results match scenario 1.
